// File: rtl/isa_int_pkg.sv
// Shared constants, state encoding and helpers for the interrupt controller.
package isa_int_pkg;

  localparam logic [10:0] ADDR_MASK_DEF  = 11'h7F0;
  localparam logic [10:0] ADDR_PEND_DEF  = 11'h7F1;
  localparam logic [10:0] ADDR_CAUSE_DEF = 11'h7F2;

  localparam int GIE_BIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } int_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_idx(input logic [14:0] v);
    lowest_idx = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchronizer for one request line, plus a history flop that
// turns the synchronized level into a single-cycle rise pulse.
module int_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_prev;

endmodule

// File: rtl/int_controller.sv
// Prioritized interrupt controller: memory-mapped enable/pending/cause
// registers and a single request/acknowledge/return handshake to the decoder.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for an eligible source
//   REQ   | int_req high for frozen cause, waiting for int_ack
//   SVC   | handler running, waiting for int_ret
module int_controller
  import isa_int_pkg::*;
#(
  parameter int          NUM_SRC    = 8,
  parameter logic [15:0] EDGE_MASK  = 16'h00FF,
  parameter logic [10:0] ADDR_MASK  = ADDR_MASK_DEF,
  parameter logic [10:0] ADDR_PEND  = ADDR_PEND_DEF,
  parameter logic [10:0] ADDR_CAUSE = ADDR_CAUSE_DEF
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [10:0]        cfg_addr,
  input  logic [15:0]        cfg_wdata,
  input  logic               cfg_we,
  output logic [15:0]        cfg_rdata,
  output logic               cfg_hit,
  output logic               int_req,
  input  logic               int_ack,
  input  logic               int_ret,
  output logic               int_active,
  output logic [3:0]         int_cause
);

  logic [NUM_SRC-1:0] w_level;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [15:0]        w_elig16;
  logic               w_we_mask;
  logic               w_we_pend;
  logic               w_ack_clr;
  logic               w_unused_bits;

  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_en;
  logic               r_gie;
  logic [3:0]         r_cause;
  logic [3:0]         w_cause_nxt;
  int_state_e         r_state;
  int_state_e         w_state_nxt;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    int_sync_edge u_sync (
      .i_clk   (CLOCK_50),
      .i_rst   (reset),
      .i_async (irq_src[gi]),
      .o_level (w_level[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  // Edge sources only ever use the rise pulse and level sources only the level.
  assign w_unused_bits = ^{cfg_wdata, w_level, w_rise};

  assign w_we_mask = cfg_we && (cfg_addr == ADDR_MASK);
  assign w_we_pend = cfg_we && (cfg_addr == ADDR_PEND);
  assign w_elig    = r_pend & r_en & {NUM_SRC{r_gie}};
  assign w_elig16  = 16'(w_elig);

  // A fresh rise beats a same-cycle W1C or ack-clear on that bit.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        w_pend_nxt[i] = w_rise[i] |
                        (r_pend[i] & ~((w_we_pend & cfg_wdata[i]) |
                                       (w_ack_clr & (r_cause == 4'(i)))));
      end else begin
        w_pend_nxt[i] = w_level[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_en    <= '0;
      r_gie   <= 1'b0;
      r_pend  <= '0;
      r_cause <= 4'd0;
    end else begin
      if (w_we_mask) begin
        r_en  <= cfg_wdata[NUM_SRC-1:0];
        r_gie <= cfg_wdata[GIE_BIT];
      end
      r_pend  <= w_pend_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_ack_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_cause_nxt = lowest_idx(15'(w_elig));
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          w_ack_clr   = 1'b1;
          w_state_nxt = SVC;
        end else if (!w_elig16[r_cause]) begin
          w_state_nxt = IDLE;
        end
      end
      SVC: begin
        if (int_ret) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign int_req    = (r_state == REQ);
  assign int_active = (r_state == SVC);
  assign int_cause  = r_cause;

  always_comb begin
    cfg_rdata = 16'h0000;
    cfg_hit   = 1'b0;
    if (cfg_addr == ADDR_MASK) begin
      cfg_hit                = 1'b1;
      cfg_rdata[NUM_SRC-1:0] = r_en;
      cfg_rdata[GIE_BIT]     = r_gie;
    end else if (cfg_addr == ADDR_PEND) begin
      cfg_hit                = 1'b1;
      cfg_rdata[NUM_SRC-1:0] = r_pend;
    end else if (cfg_addr == ADDR_CAUSE) begin
      cfg_hit        = 1'b1;
      cfg_rdata[3:0] = r_cause;
    end
  end

endmodule
